complex_div: RTL and testbench

Sequential signed complex divider for the SDFT datapath: computes q = a / b for 8-bit signed complex operands, returning a fixed-point 16-bit signed complex quotient. It is the inverse of the combinational complex multiplier. It undoes a twiddle/gain rotation or normalises a bin by a reference bin, and it sits downstream of the bin registers behind a valid/ready handshake. Internally it forms a·conj(b) and |b|², then runs two bit-serial restoring divisions in parallel.

---
 rtl/sdft_pkg.sv | 28 ++
 rtl/udiv_seq.sv | 77 +++++++
 rtl/complex_div.sv | 214 +++++++++++++++++++++
 tb/tb_complex_div.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sdft_pkg.sv
// Shared definitions for the SDFT datapath blocks.
//   - complex_div state encoding
//   - datapath widths: DW (operand), OW (quotient), NUM_W (a*conj(b)), DEN_W (|b|^2)
//   - SAT_MAX: largest quotient magnitude; the output range is symmetric
//   - num_mag(): magnitude of a signed numerator, always fits DEN_W bits
package sdft_pkg;

    localparam int DW    = 8;
    localparam int OW    = 16;
    localparam int NUM_W = 17;
    localparam int DEN_W = 16;

    localparam logic [OW-1:0] SAT_MAX = 16'd32767;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MULT = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } cdiv_state_e;

    // |v| for 8x8 complex numerators is at most 32768, so the sign bit can be dropped.
    function automatic logic [DEN_W-1:0] num_mag(input logic signed [NUM_W-1:0] v);
        return DEN_W'(v[NUM_W-1] ? -v : v);
    endfunction

endpackage

// File: rtl/udiv_seq.sv
// Unsigned bit-serial restoring divider, one quotient bit per cycle, MSB first.
//   clk, reset       : clock, asynchronous active-low reset
//   start_i          : load dividend/divisor, clear remainder, become busy
//   last_i           : the current busy cycle is the final step (from the owner's counter)
//   dividend_i       : DIVIDEND_W-bit unsigned dividend
//   divisor_i        : DIVISOR_W-bit unsigned divisor, must be non-zero
//   done_o           : high during the final step; quo_o is valid on the next cycle
//   quo_o            : quotient register
module udiv_seq #(
    parameter int DIVIDEND_W = 24,
    parameter int DIVISOR_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic                  last_i,
    input  logic [DIVIDEND_W-1:0] dividend_i,
    input  logic [DIVISOR_W-1:0]  divisor_i,
    output logic                  done_o,
    output logic [DIVIDEND_W-1:0] quo_o
);

    localparam int REM_W = DIVISOR_W + 1;

    logic [DIVIDEND_W-1:0] quo_q, quo_d;
    logic [REM_W-1:0]      rem_q, rem_d;
    logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
    logic                  busy_q, busy_d;
    logic [REM_W:0]        trial;
    logic [REM_W:0]        diff;

    // The quotient register starts holding the dividend; dividend bits shift out
    // of the top into the remainder while quotient bits shift in at the bottom.
    always_comb begin
        quo_d  = quo_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        busy_d = busy_q;
        trial  = {rem_q, quo_q[DIVIDEND_W-1]};
        diff   = trial - {2'b00, dvs_q};
        if (start_i) begin
            quo_d  = dividend_i;
            rem_d  = '0;
            dvs_d  = divisor_i;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (trial >= {2'b00, dvs_q}) begin
                rem_d = REM_W'(diff);
                quo_d = {quo_q[DIVIDEND_W-2:0], 1'b1};
            end else begin
                rem_d = REM_W'(trial);
                quo_d = {quo_q[DIVIDEND_W-2:0], 1'b0};
            end
            if (last_i) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            busy_q <= busy_d;
        end
    end

    assign done_o = busy_q & last_i;
    assign quo_o  = quo_q;

endmodule

// File: rtl/complex_div.sv
// Sequential signed complex divider q = a / b, quotient in Q(15-FRAC).FRAC.
//   clk, reset              : clock, asynchronous active-low reset
//   in_valid / in_ready     : operand handshake, in_ready only in IDLE
//   a_real, a_imag          : signed dividend
//   b_real, b_imag          : signed divisor
//   out_valid / out_ready   : result handshake, result held until accepted
//   out_real, out_imag      : signed quotient, truncated toward zero, clamped to +/-32767
//   err                     : divisor was 0+0j
//   sat                     : at least one component was clamped
//
// state | meaning
// IDLE  | waiting for operands
// MULT  | form a*conj(b) and |b|^2, start both dividers
// DIV   | N = 16+FRAC restoring steps on both components
// FIX   | clamp, apply sign, load output registers
// DONE  | result presented until out_ready
module complex_div
    import sdft_pkg::*;
#(
    parameter int FRAC = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] a_real,
    input  logic [DW-1:0] a_imag,
    input  logic [DW-1:0] b_real,
    input  logic [DW-1:0] b_imag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_real,
    output logic [OW-1:0] out_imag,
    output logic          err,
    output logic          sat
);

    localparam int N     = OW + FRAC;
    localparam int CNT_W = $clog2(N);

    cdiv_state_e state_q, state_d;

    logic signed [DW-1:0] ar_q, ai_q, br_q, bi_q;
    logic signed [DW-1:0] ar_d, ai_d, br_d, bi_d;
    logic                 neg_re_q, neg_re_d, neg_im_q, neg_im_d;
    logic                 err_flag_q, err_flag_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [OW-1:0]        out_real_q, out_real_d, out_imag_q, out_imag_d;
    logic                 err_q, err_d, sat_q, sat_d;

    logic signed [2*DW-1:0] p_rr, p_ii, p_ir, p_ri, p_bb_r, p_bb_i;
    logic signed [NUM_W-1:0] nr, ni;
    logic [DEN_W-1:0]        den;
    logic [N-1:0]            dvd_re, dvd_im;

    logic          div_start, div_last;
    logic          done_re, done_im;
    logic [N-1:0]  quo_re, quo_im;
    logic [N-1:0]  q_re, q_im;
    logic          sat_re, sat_im;
    logic [OW-1:0] m_re, m_im;

    // a * conj(b) and |b|^2 from the latched operands
    always_comb begin
        p_rr   = ar_q * br_q;
        p_ii   = ai_q * bi_q;
        p_ir   = ai_q * br_q;
        p_ri   = ar_q * bi_q;
        p_bb_r = br_q * br_q;
        p_bb_i = bi_q * bi_q;
        nr     = {p_rr[2*DW-1], p_rr} + {p_ii[2*DW-1], p_ii};
        ni     = {p_ir[2*DW-1], p_ir} - {p_ri[2*DW-1], p_ri};
        den    = DEN_W'(p_bb_r) + DEN_W'(p_bb_i);
        dvd_re = N'(num_mag(nr)) << FRAC;
        dvd_im = N'(num_mag(ni)) << FRAC;
    end

    // The divisor-zero path never starts the dividers, so their stale quotients
    // are masked here rather than relied upon.
    always_comb begin
        q_re   = err_flag_q ? '0 : quo_re;
        q_im   = err_flag_q ? '0 : quo_im;
        sat_re = q_re > N'(SAT_MAX);
        sat_im = q_im > N'(SAT_MAX);
        m_re   = sat_re ? SAT_MAX : q_re[OW-1:0];
        m_im   = sat_im ? SAT_MAX : q_im[OW-1:0];
    end

    always_comb begin
        state_d    = state_q;
        ar_d       = ar_q;
        ai_d       = ai_q;
        br_d       = br_q;
        bi_d       = bi_q;
        neg_re_d   = neg_re_q;
        neg_im_d   = neg_im_q;
        err_flag_d = err_flag_q;
        cnt_d      = cnt_q;
        out_real_d = out_real_q;
        out_imag_d = out_imag_q;
        err_d      = err_q;
        sat_d      = sat_q;
        div_start  = 1'b0;
        div_last   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    ar_d       = a_real;
                    ai_d       = a_imag;
                    br_d       = b_real;
                    bi_d       = b_imag;
                    err_flag_d = 1'b0;
                    state_d    = ST_MULT;
                end
            end
            ST_MULT: begin
                neg_re_d = nr[NUM_W-1];
                neg_im_d = ni[NUM_W-1];
                cnt_d    = CNT_W'(N - 1);
                if (den == '0) begin
                    err_flag_d = 1'b1;
                    state_d    = ST_FIX;
                end else begin
                    div_start = 1'b1;
                    state_d   = ST_DIV;
                end
            end
            ST_DIV: begin
                div_last = (cnt_q == '0);
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end
                if (done_re && done_im) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                out_real_d = neg_re_q ? (OW'(0) - m_re) : m_re;
                out_imag_d = neg_im_q ? (OW'(0) - m_im) : m_im;
                err_d      = err_flag_q;
                sat_d      = sat_re | sat_im;
                state_d    = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            ar_q       <= '0;
            ai_q       <= '0;
            br_q       <= '0;
            bi_q       <= '0;
            neg_re_q   <= 1'b0;
            neg_im_q   <= 1'b0;
            err_flag_q <= 1'b0;
            cnt_q      <= '0;
            out_real_q <= '0;
            out_imag_q <= '0;
            err_q      <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ar_q       <= ar_d;
            ai_q       <= ai_d;
            br_q       <= br_d;
            bi_q       <= bi_d;
            neg_re_q   <= neg_re_d;
            neg_im_q   <= neg_im_d;
            err_flag_q <= err_flag_d;
            cnt_q      <= cnt_d;
            out_real_q <= out_real_d;
            out_imag_q <= out_imag_d;
            err_q      <= err_d;
            sat_q      <= sat_d;
        end
    end

    udiv_seq #(.DIVIDEND_W(N), .DIVISOR_W(DEN_W)) u_div_re (
        .clk        (clk),
        .reset      (reset),
        .start_i    (div_start),
        .last_i     (div_last),
        .dividend_i (dvd_re),
        .divisor_i  (den),
        .done_o     (done_re),
        .quo_o      (quo_re)
    );

    udiv_seq #(.DIVIDEND_W(N), .DIVISOR_W(DEN_W)) u_div_im (
        .clk        (clk),
        .reset      (reset),
        .start_i    (div_start),
        .last_i     (div_last),
        .dividend_i (dvd_im),
        .divisor_i  (den),
        .done_o     (done_im),
        .quo_o      (quo_im)
    );

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_real  = out_real_q;
    assign out_imag  = out_imag_q;
    assign err       = err_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_complex_div.sv
// Self-checking bench for complex_div (FRAC=8): directed vector table, a few
// randomised vectors against an integer reference model, backpressure and
// mid-division reset sequences. Expected results flow through a scoreboard queue.
module tb_complex_div;

    localparam int FRAC = 8;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a_real, a_imag, b_real, b_imag;
    logic       out_valid;
    logic       out_ready;
    logic [15:0] out_real, out_imag;
    logic       err, sat;

    complex_div #(.FRAC(FRAC)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_real    (a_real),
        .a_imag    (a_imag),
        .b_real    (b_real),
        .b_imag    (b_imag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_real  (out_real),
        .out_imag  (out_imag),
        .err       (err),
        .sat       (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int ar, ai, br, bi;
        int re, im, e, s, lat;
    } vec_t;

    vec_t sb_q[$];
    vec_t tbl[8];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Straight integer arithmetic: truncating division of the scaled magnitude.
    function automatic vec_t model(input int ar, input int ai, input int br, input int bi);
        vec_t v;
        int nr, ni, den, qr, qi;
        v.ar = ar; v.ai = ai; v.br = br; v.bi = bi;
        den = br * br + bi * bi;
        nr  = ar * br + ai * bi;
        ni  = ai * br - ar * bi;
        v.s = 0;
        if (den == 0) begin
            v.re = 0; v.im = 0; v.e = 1; v.lat = 3;
        end else begin
            qr = (iabs(nr) * (1 << FRAC)) / den;
            qi = (iabs(ni) * (1 << FRAC)) / den;
            if (qr > 32767) begin qr = 32767; v.s = 1; end
            if (qi > 32767) begin qi = 32767; v.s = 1; end
            v.re = (nr < 0) ? -qr : qr;
            v.im = (ni < 0) ? -qi : qi;
            v.e  = 0;
            v.lat = 16 + FRAC + 3;
        end
        return v;
    endfunction

    // Waits for in_ready, presents operands, and returns #1 after the accepting edge.
    task automatic accept_op(input vec_t v);
        int t;
        t = 0;
        while (!in_ready && t < 100) begin
            @(posedge clk); #1; t++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        in_valid = 1'b1;
        a_real = 8'(v.ar); a_imag = 8'(v.ai);
        b_real = 8'(v.br); b_imag = 8'(v.bi);
        @(posedge clk); #1;
        in_valid = 1'b0;
        sb_q.push_back(v);
    endtask

    // Counts edges from acceptance (the accepting edge is edge 1) until out_valid.
    task automatic wait_result(output int k);
        k = 1;
        while (!out_valid && k < 200) begin
            @(posedge clk); #1; k++;
        end
    endtask

    task automatic compare_result(input string tag, input int k);
        vec_t e;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 0, 1);
            return;
        end
        e = sb_q.pop_front();
        check({tag, "_latency"}, k, e.lat);
        check({tag, "_out_valid"}, int'(out_valid), 1);
        check({tag, "_re"}, int'($signed(out_real)), e.re);
        check({tag, "_im"}, int'($signed(out_imag)), e.im);
        check({tag, "_err"}, int'(err), e.e);
        check({tag, "_sat"}, int'(sat), e.s);
    endtask

    task automatic handshake_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic do_op(input string tag, input vec_t v);
        int k;
        accept_op(v);
        wait_result(k);
        compare_result(tag, k);
        handshake_out();
    endtask

    initial begin
        int   k;
        int   hits;
        vec_t v;

        tbl[0] = '{ar:   7, ai:  -1, br:  2, bi: -1, re:    768, im:    256, e: 0, s: 0, lat: 27};
        tbl[1] = '{ar:   0, ai:  12, br: -2, bi: -2, re:   -768, im:   -768, e: 0, s: 0, lat: 27};
        tbl[2] = '{ar:   1, ai:   0, br:  3, bi:  0, re:     85, im:      0, e: 0, s: 0, lat: 27};
        tbl[3] = '{ar:  -1, ai:   0, br:  3, bi:  0, re:    -85, im:      0, e: 0, s: 0, lat: 27};
        tbl[4] = '{ar:   5, ai:  -9, br:  0, bi:  0, re:      0, im:      0, e: 1, s: 0, lat: 3};
        tbl[5] = '{ar: -128, ai: -128, br: 1, bi:  0, re: -32767, im: -32767, e: 0, s: 1, lat: 27};
        tbl[6] = '{ar: 127, ai: 127, br:  1, bi:  0, re:  32512, im:  32512, e: 0, s: 0, lat: 27};
        tbl[7] = '{ar: -128, ai: -128, br: 0, bi:  0, re:     0, im:      0, e: 1, s: 0, lat: 3};

        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a_real = '0; a_imag = '0; b_real = '0; b_imag = '0;
        #12;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_real", int'(out_real), 0);
        check("rst_out_imag", int'(out_imag), 0);
        check("rst_err", int'(err), 0);
        check("rst_sat", int'(sat), 0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            do_op($sformatf("vec%0d", i), tbl[i]);
        end

        for (int i = 0; i < 6; i++) begin
            int ar, ai, br, bi;
            ar = int'($urandom_range(0, 255)) - 128;
            ai = int'($urandom_range(0, 255)) - 128;
            br = int'($urandom_range(0, 15)) - 8;
            bi = int'($urandom_range(0, 255)) - 128;
            do_op($sformatf("rnd%0d", i), model(ar, ai, br, bi));
        end

        // Backpressure: result held for 10 cycles while new operands are offered.
        accept_op(tbl[0]);
        wait_result(k);
        compare_result("bp", k);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            a_real = 8'sd1; a_imag = 8'sd0; b_real = 8'sd3; b_imag = 8'sd0;
            @(posedge clk); #1;
            check($sformatf("bp_in_ready_%0d", i), int'(in_ready), 0);
            check($sformatf("bp_valid_%0d", i), int'(out_valid), 1);
            check($sformatf("bp_re_%0d", i), int'($signed(out_real)), 768);
            check($sformatf("bp_im_%0d", i), int'($signed(out_imag)), 256);
        end
        in_valid = 1'b0;
        handshake_out();
        check("bp_after_valid", int'(out_valid), 0);
        check("bp_after_in_ready", int'(in_ready), 1);
        hits = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) hits++;
        end
        check("bp_no_queued_result", hits, 0);

        // Reset during DIV aborts the division with no stale result afterwards.
        accept_op(tbl[1]);
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("rst_div_out_valid", int'(out_valid), 0);
        check("rst_div_in_ready", int'(in_ready), 1);
        check("rst_div_out_real", int'(out_real), 0);
        check("rst_div_err", int'(err), 0);
        sb_q.delete();
        @(negedge clk); reset = 1'b1;
        hits = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) hits++;
        end
        check("rst_div_no_stale", hits, 0);
        do_op("post_rst", tbl[2]);
        do_op("post_rst2", tbl[0]);

        check("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
